// File: rtl/jsv_timer_pkg.sv
// Shared definitions for the interval-timer driver: register map, control bits, FSM states.
package jsv_timer_pkg;

    // Word addresses on the Avalon-MM bus
    localparam logic [3:0] AddrStatus  = 4'd0;
    localparam logic [3:0] AddrControl = 4'd1;
    localparam logic [3:0] AddrPeriod0 = 4'd2;
    localparam logic [3:0] AddrSnap0   = 4'd6;

    // Control register bit positions
    localparam int unsigned CtrlIto   = 0;
    localparam int unsigned CtrlCont  = 1;
    localparam int unsigned CtrlStart = 2;
    localparam int unsigned CtrlStop  = 3;

    typedef enum logic [2:0] {
        StIdle,
        StWrPer,
        StWrCtrl,
        StRun,
        StAck,
        StSnapWr,
        StSnapRd,
        StWrStop
    } state_e;

    // Control word that starts the timer with interrupts enabled
    function automatic logic [15:0] ctrl_start_word(input logic cont);
        logic [15:0] w;
        w            = '0;
        w[CtrlIto]   = 1'b1;
        w[CtrlCont]  = cont;
        w[CtrlStart] = 1'b1;
        return w;
    endfunction

    // Control word that stops the timer
    function automatic logic [15:0] ctrl_stop_word();
        logic [15:0] w;
        w           = '0;
        w[CtrlStop] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/jsv_avmm_seq.sv
// Single-access Avalon-MM initiator: one-cycle writes, two-cycle reads.
// The caller holds req_i (with address/data) until done_o; a new request may be
// presented in the same cycle as done_o, giving back-to-back accesses.
module jsv_avmm_seq (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        req_write_i,
    input  logic [3:0]  req_addr_i,
    input  logic [15:0] req_wdata_i,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic [3:0]  av_address_o,
    output logic        av_chipselect_o,
    output logic        av_write_n_o,
    output logic [15:0] av_writedata_o,
    input  logic [15:0] av_readdata_i
);

    logic active;
    logic rd_phase_b_q;

    // Reset drops the bus in the same cycle it is asserted
    assign active = req_i & ~reset_i;

    // Tracks whether a read is in its second (capture) cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_phase_b_q <= 1'b0;
        end else if (active && !req_write_i) begin
            rd_phase_b_q <= ~rd_phase_b_q;
        end else begin
            rd_phase_b_q <= 1'b0;
        end
    end

    // Bus drive and completion; idle bus is chipselect=0, write_n=1, zeros
    always_comb begin
        av_chipselect_o = active;
        av_write_n_o    = ~(active & req_write_i);
        av_address_o    = active ? req_addr_i : 4'd0;
        av_writedata_o  = (active && req_write_i) ? req_wdata_i : 16'd0;
        done_o          = active & (req_write_i | rd_phase_b_q);
        rdata_o         = av_readdata_i;
    end

endmodule

// File: rtl/jsv_timer_driver.sv
// Driver FSM for an Avalon-MM interval timer: programs period/control,
// acknowledges timeouts, takes 64-bit counter snapshots and stops the timer.
module jsv_timer_driver
    import jsv_timer_pkg::*;
#(
    parameter int unsigned TICK_W   = 32,
    parameter bit          AUTO_ACK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_snap,
    output logic              busy,
    output logic              running,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] tick_count,
    output logic [63:0]       snap_value,
    output logic              snap_valid,
    output logic [3:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              av_irq
);

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic              from_run_q, from_run_d;
    logic [63:0]       period_q, period_d;
    logic              cont_q, cont_d;
    logic [TICK_W-1:0] tick_count_q, tick_count_d;
    logic              tick_pulse_q, tick_pulse_d;
    logic [47:0]       snap_acc_q, snap_acc_d;
    logic [63:0]       snap_value_q, snap_value_d;
    logic              snap_valid_q, snap_valid_d;
    logic              irq_q;

    logic              req, req_write, seq_done;
    logic [3:0]        req_addr;
    logic [15:0]       req_wdata, seq_rdata;
    logic              irq_event;

    jsv_avmm_seq u_seq (
        .clk_i           (clk),
        .reset_i         (reset),
        .req_i           (req),
        .req_write_i     (req_write),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .done_o          (seq_done),
        .rdata_o         (seq_rdata),
        .av_address_o    (av_address),
        .av_chipselect_o (av_chipselect),
        .av_write_n_o    (av_write_n),
        .av_writedata_o  (av_writedata),
        .av_readdata_i   (av_readdata)
    );

    // Without auto-ack the irq is never cleared by us, so only its rising edge counts
    assign irq_event = AUTO_ACK ? av_irq : (av_irq & ~irq_q);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            beat_q       <= 2'd0;
            from_run_q   <= 1'b0;
            period_q     <= 64'd0;
            cont_q       <= 1'b0;
            tick_count_q <= '0;
            tick_pulse_q <= 1'b0;
            snap_acc_q   <= 48'd0;
            snap_value_q <= 64'd0;
            snap_valid_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            from_run_q   <= from_run_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            tick_count_q <= tick_count_d;
            tick_pulse_q <= tick_pulse_d;
            snap_acc_q   <= snap_acc_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            irq_q        <= av_irq;
        end
    end

    // Next-state logic and bus-access requests
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        from_run_d   = from_run_q;
        period_d     = period_q;
        cont_d       = cont_q;
        tick_count_d = tick_count_q;
        tick_pulse_d = 1'b0;
        snap_acc_d   = snap_acc_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
        req          = 1'b0;
        req_write    = 1'b1;
        req_addr     = 4'd0;
        req_wdata    = 16'd0;

        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    state_d      = StWrPer;
                    beat_d       = 2'd0;
                    period_d     = cfg_period;
                    cont_d       = cfg_continuous;
                    tick_count_d = '0;
                end else if (cmd_snap) begin
                    state_d    = StSnapWr;
                    from_run_d = 1'b0;
                end
            end
            StWrPer: begin
                req       = 1'b1;
                req_addr  = AddrPeriod0 + {2'b00, beat_q};
                req_wdata = period_q[{beat_q, 4'b0000} +: 16];
                if (seq_done) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StWrCtrl;
                    end
                end
            end
            StWrCtrl: begin
                req       = 1'b1;
                req_addr  = AddrControl;
                req_wdata = ctrl_start_word(cont_q);
                if (seq_done) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Stop beats irq beats snap; a level irq left pending is taken on return
                if (cmd_stop) begin
                    state_d = StWrStop;
                end else if (irq_event) begin
                    state_d = StAck;
                end else if (cmd_snap) begin
                    state_d    = StSnapWr;
                    from_run_d = 1'b1;
                end
            end
            StAck: begin
                if (AUTO_ACK) begin
                    req      = 1'b1;
                    req_addr = AddrStatus;
                end
                if (!AUTO_ACK || seq_done) begin
                    tick_pulse_d = 1'b1;
                    tick_count_d = tick_count_q + TICK_W'(1);
                    state_d      = cont_q ? StRun : StIdle;
                end
            end
            StSnapWr: begin
                req      = 1'b1;
                req_addr = AddrSnap0;
                if (seq_done) begin
                    state_d = StSnapRd;
                    beat_d  = 2'd0;
                end
            end
            StSnapRd: begin
                req       = 1'b1;
                req_write = 1'b0;
                req_addr  = AddrSnap0 + {2'b00, beat_q};
                if (seq_done) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        snap_value_d = {seq_rdata, snap_acc_q};
                        snap_valid_d = 1'b1;
                        state_d      = from_run_q ? StRun : StIdle;
                    end else begin
                        // Halfwords arrive LS first; shift each in from the top
                        snap_acc_d = {seq_rdata, snap_acc_q[47:16]};
                    end
                end
            end
            StWrStop: begin
                req       = 1'b1;
                req_addr  = AddrControl;
                req_wdata = ctrl_stop_word();
                if (seq_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs
    always_comb begin
        busy       = (state_q != StIdle) && (state_q != StRun);
        running    = (state_q == StRun) || (state_q == StAck) ||
                     (((state_q == StSnapWr) || (state_q == StSnapRd)) && from_run_q);
        tick_pulse = tick_pulse_q;
        tick_count = tick_count_q;
        snap_value = snap_value_q;
        snap_valid = snap_valid_q;
    end

endmodule

// File: doc/jsv_timer_driver.md
JSV_TIMER_DRIVER -- requirements
Module: jsv_timer_driver

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter TICK_W, 32, width of the timeout tick counter.
REQ-002 SHALL have parameter AUTO_ACK, 1; when 1, every irq is cleared automatically by a status write.

Ports (name  direction  width  meaning):
REQ-003 SHALL have clk  in  1  single clock; reset is synchronous and active-high.
REQ-004 SHALL have reset  in  1  synchronous active-high reset.
REQ-005 SHALL have cfg_period  in  64  period to program; sampled on cmd_start.
REQ-006 SHALL have cfg_continuous  in  1  continuous-mode bit; sampled on cmd_start.
REQ-007 SHALL have cmd_start, cmd_stop, cmd_snap  in  1 each  single-cycle command pulses.
REQ-008 SHALL have busy  out  1  high whenever the FSM is outside IDLE and RUN.
REQ-009 SHALL have running  out  1  high in RUN and in ACK/SNAP sequences entered from RUN.
REQ-010 SHALL have tick_pulse  out  1  one-cycle pulse per acknowledged timeout.
REQ-011 SHALL have tick_count  out  TICK_W  acknowledged timeouts since last start; wraps modulo 2^TICK_W.
REQ-012 SHALL have snap_value  out  64  last captured counter snapshot; snap_valid  out  1  one-cycle pulse when it updates.
REQ-013 SHALL have Avalon-MM initiator ports av_address out 4, av_chipselect out 1, av_write_n out 1, av_writedata out 16, av_readdata in 16, av_irq in 1.

Function
REQ-014 Register map driven: 0 status, 1 control, 2-5 period halfwords 0-3 (LS first), 6-9 snapshot halfwords 0-3; word addressed; no waitrequest.
REQ-015 Write access SHALL be one cycle: chipselect=1, write_n=0, address and writedata valid that cycle only.
REQ-016 Read access SHALL be two cycles with address held and write_n=1: cycle A presents address, cycle B holds it and captures av_readdata at end of B.
REQ-017 Between accesses chipselect=0, write_n=1; no access is ever issued in IDLE or RUN.
REQ-018 FSM states: IDLE, WR_PER (4 beats, addr 2..5), WR_CTRL, RUN, ACK, SNAP_WR, SNAP_RD (4 reads, addr 6..9), WR_STOP.
REQ-019 IDLE + cmd_start -> WR_PER; latch cfg_period/cfg_continuous; clear tick_count.
REQ-020 WR_PER -> WR_CTRL writing {STOP=0,START=1,CONT=cfg_continuous,ITO=1} (=0x5 or 0x7) -> RUN; start-to-RUN latency 5 cycles.
REQ-021 RUN + av_irq with AUTO_ACK=1 -> ACK: write 0x0000 to address 0, then tick_pulse, tick_count+1, return to RUN (or IDLE if one-shot).
REQ-022 RUN + cmd_snap -> SNAP_WR (write 0 to address 6) -> SNAP_RD; assemble 64 bits LS-halfword first; snap_value and snap_valid update after the 4th capture; return to origin state.
REQ-023 IDLE + cmd_snap SHALL also perform the snapshot sequence and return to IDLE.
REQ-024 RUN + cmd_stop -> WR_STOP: write 0x8 to address 1, then IDLE.
REQ-025 Priority in RUN when simultaneous: cmd_stop > av_irq > cmd_snap; losers are dropped, except a pending irq which is serviced once the sequence ends and av_irq still high.
REQ-026 Commands arriving while busy SHALL be ignored; cmd_start in RUN SHALL be ignored.
REQ-027 One-shot mode: after ACK the FSM SHALL go to IDLE and deassert running.

Reset
REQ-028 On reset: FSM IDLE; av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0; busy=0, running=0, tick_pulse=0, snap_valid=0, tick_count=0, snap_value=0.
REQ-029 Reset mid-access SHALL abort the access in the same cycle; no partial snap_valid.

Structure
REQ-030 Register addresses, control bit positions and the state enum SHALL live in package jsv_timer_pkg.
REQ-031 One sub-module jsv_avmm_seq SHALL issue single write/read accesses with a req/done handshake; the FSM sequences it.

Verification (bench pairs driver with the timer slave, period 49999 reset default)
REQ-032 cmd_start, period=0x0000_0000_0000_0009, continuous=1 -> writes 0x9,0,0,0 to addr 2-5, 0x7 to addr 1; tick_pulse every 10 clocks plus ack latency; tick_count increments.
REQ-033 One-shot, period=4 -> single tick, tick_count=1, running=0, FSM IDLE.
REQ-034 cmd_snap in RUN -> write addr 6, reads addr 6-9; snap_value equals slave counter at snap write; snap_valid one pulse.
REQ-035 cmd_stop and av_irq same cycle -> control write 0x8 first, no tick_pulse, ends IDLE.
REQ-036 tick_count preset near 2^TICK_W-1 (TICK_W=4) -> wraps 15 to 0.
REQ-037 reset asserted during SNAP_RD -> next cycle chipselect=0, snap_valid never pulses, FSM IDLE.
